// File: rtl/xcom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xcom_pkg
// Description : Shared opcode and executor-state definitions for the XCOM
//               core-clock command executor.
// Revision    : 1.0 - initial release
// ============================================================================
package xcom_pkg;

  // Opcodes 8..15 are reserved; they are recognised by bit 3 alone.
  typedef enum logic [3:0] {
    XOP_NOP     = 4'd0,
    XOP_FLG_CLR = 4'd1,
    XOP_FLG_SET = 4'd2,
    XOP_REG0_WR = 4'd3,
    XOP_REG1_WR = 4'd4,
    XOP_SYNC    = 4'd5,
    XOP_QRST    = 4'd6,
    XOP_QSTART  = 4'd7
  } xcom_op_e;

  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_DEC   = 2'd1,
    E_WAIT  = 2'd2,
    E_PULSE = 2'd3
  } TYPE_EXEC_ST;

  // FIFO word layout: {op[39:36], dt[35:4], id[3:0]}
  localparam int XCMD_W = 40;

  function automatic logic op_is_reserved(input logic [3:0] op);
    return op[3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/xcom_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xcom_cmd_fifo
// Description : Synchronous command FIFO, depth 2**AW, first-word fall-through
//               read data (o_rdata always shows the head entry).
// Ports       : c_clk_i/c_rst_ni  clock, async active-low reset
//               i_push/i_wdata    write strobe and data (ignored when full)
//               i_pop             advance head (ignored when empty)
//               o_rdata           head entry
//               o_full/o_empty    status flags
//               o_count           current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module xcom_cmd_fifo #(
  parameter int AW = 2,
  parameter int DW = 40
) (
  input  logic          c_clk_i,
  input  logic          c_rst_ni,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] c_ptr_one = (AW+1)'(1);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = i_push & ~o_full;
  assign w_rd = i_pop & ~o_empty;

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + c_ptr_one;
      if (w_rd) r_rptr <= r_rptr + c_ptr_one;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge c_clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign o_count = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/xcom_cmd_exec.sv
`default_nettype none
// ============================================================================
// Module      : xcom_cmd_exec
// Description : Core-clock executor for XCOM RX commands. Queues strobes in a
//               small FIFO and executes them in order (flag/register writes,
//               timed SYNC pulse, tProc reset/start pulses).
// Ports       : c_clk_i, c_rst_ni             clock, async active-low reset
//               cmd_vld_i/op/dt/id            command strobe and fields
//               clr_err_i                     clears ovf_o / err_o
//               flag_o, reg0_o, reg1_o        executed state
//               sync_o, qp_rst_o, qp_start_o  timed pulses
//               busy_o, last_id_o, cmd_cnt_o  status
//               ovf_o, err_o                  sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module xcom_cmd_exec
  import xcom_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter int PULSE_LEN = 4,
  parameter int SYNC_W    = 16
) (
  input  logic        c_clk_i,
  input  logic        c_rst_ni,
  input  logic        cmd_vld_i,
  input  logic [3:0]  cmd_op_i,
  input  logic [31:0] cmd_dt_i,
  input  logic [3:0]  cmd_id_i,
  input  logic        clr_err_i,
  output logic        flag_o,
  output logic [31:0] reg0_o,
  output logic [31:0] reg1_o,
  output logic        sync_o,
  output logic        qp_rst_o,
  output logic        qp_start_o,
  output logic        busy_o,
  output logic [3:0]  last_id_o,
  output logic [15:0] cmd_cnt_o,
  output logic        ovf_o,
  output logic        err_o
);

  localparam logic [SYNC_W-1:0] c_cnt_one   = SYNC_W'(1);
  localparam logic [SYNC_W-1:0] c_pulse_len = SYNC_W'(PULSE_LEN);

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_AW:0]  w_fcount;
  logic [FIFO_AW:0]  w_fcount_nxt;
  logic [XCMD_W-1:0] w_rdata;
  TYPE_EXEC_ST       w_state_nxt;
  logic [SYNC_W-1:0] w_cnt_nxt;
  logic              w_err_set;
  logic              w_ovf_set;

  TYPE_EXEC_ST       r_state;
  logic [SYNC_W-1:0] r_cnt;
  logic [3:0]        r_op;
  logic [31:0]       r_dt;
  logic [3:0]        r_id;
  logic              r_flag;
  logic [31:0]       r_reg0;
  logic [31:0]       r_reg1;
  logic              r_sync;
  logic              r_qp_rst;
  logic              r_qp_start;
  logic              r_busy;
  logic [3:0]        r_last_id;
  logic [15:0]       r_cmd_cnt;
  logic              r_ovf;
  logic              r_err;

  assign w_push = cmd_vld_i & ~w_full;

  xcom_cmd_fifo #(
    .AW (FIFO_AW),
    .DW (XCMD_W)
  ) u_fifo (
    .c_clk_i  (c_clk_i),
    .c_rst_ni (c_rst_ni),
    .i_push   (w_push),
    .i_wdata  ({cmd_op_i, cmd_dt_i, cmd_id_i}),
    .i_pop    (w_pop),
    .o_rdata  (w_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_fcount)
  );

  // ---------------- FSM state register ----------------
  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) r_state <= E_IDLE;
    else           r_state <= w_state_nxt;
  end

  // ---------------- FSM next state / shared counter ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      E_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = E_DEC;
        end
      end
      E_DEC: begin
        if (r_op == XOP_SYNC) begin
          w_state_nxt = E_WAIT;
          w_cnt_nxt   = r_dt[SYNC_W-1:0];
        end else if ((r_op == XOP_QRST) || (r_op == XOP_QSTART)) begin
          w_state_nxt = E_PULSE;
          w_cnt_nxt   = c_pulse_len;
        end else begin
          w_state_nxt = E_IDLE;
        end
      end
      E_WAIT: begin
        if (r_cnt == '0) w_state_nxt = E_IDLE;
        else             w_cnt_nxt   = r_cnt - c_cnt_one;
      end
      E_PULSE: begin
        // Counter runs PULSE_LEN..1, one E_PULSE cycle per value.
        if (r_cnt <= c_cnt_one) w_state_nxt = E_IDLE;
        else                    w_cnt_nxt   = r_cnt - c_cnt_one;
      end
      default: w_state_nxt = E_IDLE;
    endcase
  end

  assign w_err_set    = (r_state == E_DEC) && op_is_reserved(r_op);
  assign w_ovf_set    = cmd_vld_i & w_full;
  assign w_fcount_nxt = w_fcount + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

  // ---------------- datapath and output registers ----------------
  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_dt       <= '0;
      r_id       <= '0;
      r_flag     <= 1'b0;
      r_reg0     <= '0;
      r_reg1     <= '0;
      r_sync     <= 1'b0;
      r_qp_rst   <= 1'b0;
      r_qp_start <= 1'b0;
      r_busy     <= 1'b0;
      r_last_id  <= '0;
      r_cmd_cnt  <= '0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_pop) begin
        r_op <= w_rdata[39:36];
        r_dt <= w_rdata[35:4];
        r_id <= w_rdata[3:0];
      end
      if (r_state == E_DEC) begin
        r_last_id <= r_id;
        r_cmd_cnt <= r_cmd_cnt + 16'd1;
        case (r_op)
          XOP_FLG_CLR: r_flag <= 1'b0;
          XOP_FLG_SET: r_flag <= 1'b1;
          XOP_REG0_WR: r_reg0 <= r_dt;
          XOP_REG1_WR: r_reg1 <= r_dt;
          default:     ;
        endcase
      end
      // Pulses are registered from next-state so they line up with the
      // cycle the FSM spends in the corresponding state.
      r_sync     <= (w_state_nxt == E_WAIT) && (w_cnt_nxt == '0);
      r_qp_rst   <= (w_state_nxt == E_PULSE) && (r_op == XOP_QRST);
      r_qp_start <= (w_state_nxt == E_PULSE) && (r_op == XOP_QSTART);
      r_busy     <= (w_fcount_nxt != '0) || (w_state_nxt != E_IDLE);
      // A new error in the clear cycle wins.
      r_ovf      <= w_ovf_set | (r_ovf & ~clr_err_i);
      r_err      <= w_err_set | (r_err & ~clr_err_i);
    end
  end

  assign flag_o     = r_flag;
  assign reg0_o     = r_reg0;
  assign reg1_o     = r_reg1;
  assign sync_o     = r_sync;
  assign qp_rst_o   = r_qp_rst;
  assign qp_start_o = r_qp_start;
  assign busy_o     = r_busy;
  assign last_id_o  = r_last_id;
  assign cmd_cnt_o  = r_cmd_cnt;
  assign ovf_o      = r_ovf;
  assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xcom_cmd_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_xcom_cmd_exec
// Description : Scoreboard bench for xcom_cmd_exec. Each issued command is
//               turned into expected events (apply edge and resulting state,
//               SYNC edge, pulse edges, busy interval) using per-opcode
//               durations; a monitor pops and compares as the DUT presents
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xcom_cmd_exec;

  localparam int DEPTH = 4;
  localparam int PL    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  op = '0;
  logic [3:0]  id = '0;
  logic [31:0] dt = '0;

  logic        flag_o, sync_o, qp_rst_o, qp_start_o, busy_o, ovf_o, err_o;
  logic [31:0] reg0_o, reg1_o;
  logic [3:0]  last_id_o;
  logic [15:0] cmd_cnt_o;

  xcom_cmd_exec #(.FIFO_AW(2), .PULSE_LEN(PL), .SYNC_W(16)) dut (
    .c_clk_i   (clk),
    .c_rst_ni  (rst_n),
    .cmd_vld_i (vld),
    .cmd_op_i  (op),
    .cmd_dt_i  (dt),
    .cmd_id_i  (id),
    .clr_err_i (clr),
    .flag_o    (flag_o),
    .reg0_o    (reg0_o),
    .reg1_o    (reg1_o),
    .sync_o    (sync_o),
    .qp_rst_o  (qp_rst_o),
    .qp_start_o(qp_start_o),
    .busy_o    (busy_o),
    .last_id_o (last_id_o),
    .cmd_cnt_o (cmd_cnt_o),
    .ovf_o     (ovf_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int ec = 0;  // number of rising edges so far
  always @(posedge clk) ec = ec + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          edge_n;
    logic [15:0] cnt;
    logic [3:0]  id;
    logic        flag;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        err;
  } exp_cmd_t;

  exp_cmd_t q_cmd[$];
  int q_sync[$], q_rst[$], q_start[$], q_pop[$], b_lo[$], b_hi[$];

  // Reference state
  int          m_free = 0;
  logic        m_flag = 0, m_err = 0, m_ovf = 0;
  logic [31:0] m_r0 = 0, m_r1 = 0;
  logic [15:0] m_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ec);
    end
  endtask

  task automatic model_reset();
    q_cmd.delete(); q_sync.delete(); q_rst.delete(); q_start.delete();
    q_pop.delete(); b_lo.delete(); b_hi.delete();
    m_free = 0; m_flag = 0; m_err = 0; m_ovf = 0; m_r0 = 0; m_r1 = 0; m_cnt = 0;
  endtask

  // Called just after a rising edge; the strobe is sampled at edge e = ec+1.
  // A command popped at edge p is applied at p+1; the executor can pop again
  // at p+2 (simple), p+3+dt (SYNC) or p+2+PL (pulse).
  task automatic issue(input logic [3:0] o, input logic [31:0] d, input logic [3:0] i);
    int e, p, a, fr, w;
    exp_cmd_t r;
    e = ec + 1;
    while (q_pop.size() > 0 && q_pop[0] < e) void'(q_pop.pop_front());
    op = o; dt = d; id = i; vld = 1'b1;
    if (q_pop.size() < DEPTH) begin
      p  = (e + 1 > m_free) ? e + 1 : m_free;
      a  = p + 1;
      fr = p + 2;
      w  = int'(d[15:0]);
      q_pop.push_back(p);
      m_cnt = m_cnt + 16'd1;
      case (o)
        4'd1: m_flag = 1'b0;
        4'd2: m_flag = 1'b1;
        4'd3: m_r0 = d;
        4'd4: m_r1 = d;
        4'd5: begin q_sync.push_back(a + w); fr = p + 3 + w; end
        4'd6: begin for (int k = 1; k <= PL; k++) q_rst.push_back(p + k);   fr = p + 2 + PL; end
        4'd7: begin for (int k = 1; k <= PL; k++) q_start.push_back(p + k); fr = p + 2 + PL; end
        default: if (o >= 4'd8) m_err = 1'b1;
      endcase
      m_free = fr;
      r.edge_n = a; r.cnt = m_cnt; r.id = i; r.flag = m_flag;
      r.r0 = m_r0; r.r1 = m_r1; r.err = m_err;
      q_cmd.push_back(r);
      b_lo.push_back(e);
      b_hi.push_back(fr - 2);
    end else begin
      m_ovf = 1'b1;
    end
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < lim);
    if (busy_o) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy_o still %0b after %0d cycles", busy_o, lim);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_err();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    m_err = 1'b0; m_ovf = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [15:0] prev_cnt = 0;
  exp_cmd_t    ce;
  logic        eb;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cnt = 0;
    end else begin
      while (b_hi.size() > 0 && b_hi[0] < ec) begin
        void'(b_hi.pop_front()); void'(b_lo.pop_front());
      end
      eb = 1'b0;
      foreach (b_lo[k]) if (b_lo[k] <= ec && ec <= b_hi[k]) eb = 1'b1;
      chk("busy", busy_o, eb);
      if (cmd_cnt_o != prev_cnt) begin
        if (q_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
        else begin
          ce = q_cmd.pop_front();
          chk("cmd_edge", ec, ce.edge_n);
          chk("cmd_cnt", cmd_cnt_o, ce.cnt);
          chk("last_id", last_id_o, ce.id);
          chk("flag", flag_o, ce.flag);
          chk("reg0", reg0_o, ce.r0);
          chk("reg1", reg1_o, ce.r1);
          chk("err", err_o, ce.err);
        end
      end
      prev_cnt = cmd_cnt_o;
      if (sync_o) begin
        if (q_sync.size() == 0) chk("sync_unexpected", 1, 0);
        else chk("sync_edge", ec, q_sync.pop_front());
      end
      if (qp_rst_o) begin
        if (q_rst.size() == 0) chk("qrst_unexpected", 1, 0);
        else chk("qrst_edge", ec, q_rst.pop_front());
      end
      if (qp_start_o) begin
        if (q_start.size() == 0) chk("qstart_unexpected", 1, 0);
        else chk("qstart_edge", ec, q_start.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] rop;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {flag_o, sync_o, qp_rst_o, qp_start_o, busy_o, ovf_o, err_o}, 7'd0);
    chk("rst_regs", {reg0_o, reg1_o}, 64'd0);
    chk("rst_cnt", {last_id_o, cmd_cnt_o}, 20'd0);
    rst_n = 1'b1;
    idle_cycles(1);

    // 1: REG0_WR latency
    issue(4'd3, 32'hDEADBEEF, 4'd3);
    @(negedge clk); @(negedge clk);
    chk("t1_reg0_not_yet", reg0_o, 32'd0);
    @(negedge clk);
    chk("t1_reg0", reg0_o, 32'hDEADBEEF);
    chk("t1_id", last_id_o, 4'd3);
    chk("t1_cnt", cmd_cnt_o, 16'd1);
    @(posedge clk); #1;
    wait_idle(20);

    // 2: SYNC dt=5, FLG_SET two cycles later
    issue(4'd5, 32'd5, 4'd1);
    idle_cycles(1);
    issue(4'd2, 32'd0, 4'd2);
    wait_idle(50);
    chk("t2_flag", flag_o, 1'b1);

    // 3: long SYNC then 5 back-to-back strobes, last one dropped
    issue(4'd5, 32'd100, 4'd4);
    issue(4'd3, 32'h11111111, 4'd5);
    issue(4'd4, 32'h22222222, 4'd6);
    issue(4'd1, 32'd0, 4'd7);
    issue(4'd3, 32'h33333333, 4'd8);
    issue(4'd3, 32'h44444444, 4'd9);
    @(negedge clk);
    chk("t3_ovf", ovf_o, 1'b1);
    @(posedge clk); #1;
    wait_idle(300);
    chk("t3_reg0", reg0_o, 32'h33333333);
    chk("t3_flag", flag_o, 1'b0);
    clear_err();
    @(negedge clk);
    chk("t3_ovf_clr", ovf_o, 1'b0);
    @(posedge clk); #1;

    // 4: QRST then QSTART back-to-back
    issue(4'd6, 32'd0, 4'd10);
    issue(4'd7, 32'd0, 4'd11);
    wait_idle(50);

    // 5: reserved opcode, clear, clear coincident with a new error
    issue(4'hA, 32'hFFFF0000, 4'd12);
    wait_idle(20);
    chk("t5_err", err_o, 1'b1);
    clear_err();
    @(negedge clk);
    chk("t5_err_clr", err_o, 1'b0);
    @(posedge clk); #1;
    issue(4'hA, 32'd0, 4'd13);       // applied two edges after its strobe
    idle_cycles(0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("t5_err_wins", err_o, 1'b1);
    @(posedge clk); #1;
    wait_idle(20);
    clear_err();

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      rop = 4'($urandom_range(0, 10));
      if (rop == 4'd5) issue(rop, 32'($urandom_range(0, 6)), 4'($urandom));
      else             issue(rop, $urandom, 4'($urandom));
      idle_cycles($urandom_range(0, 3));
    end
    wait_idle(500);
    chk("rnd_ovf", ovf_o, m_ovf);
    chk("rnd_err", err_o, m_err);

    // 6: reset in the middle of a SYNC wait
    issue(4'd5, 32'd50, 4'd7);
    idle_cycles(10);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {flag_o, sync_o, qp_rst_o, qp_start_o, busy_o, ovf_o, err_o}, 7'd0);
    chk("t6_rst_regs", {reg0_o, reg1_o}, 64'd0);
    chk("t6_rst_cnt", {last_id_o, cmd_cnt_o}, 20'd0);
    model_reset();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(60);
    chk("t6_busy_after", busy_o, 1'b0);
    chk("t6_sync_never", sync_o, 1'b0);
    issue(4'd4, 32'hCAFEF00D, 4'd2);
    wait_idle(20);

    chk("end_q_cmd", q_cmd.size(), 0);
    chk("end_q_sync", q_sync.size(), 0);
    chk("end_q_rst", q_rst.size(), 0);
    chk("end_q_start", q_start.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
